// File: rtl/data_mem_ctrl.sv
// Purpose : sequences one EX/MEM load/store into a single req/addr_ok/data_ok SRAM transaction,
//           builds byte strobes and lane-replicated store data, and sign/zero-extends load data.
// Latency : accept -> ADDR -> DATA -> DONE; 3 cycles to resp_valid on a zero-wait bus, +1 per bus wait cycle.
// Backpr. : req_ready only in IDLE; stallreq freezes the pipeline from the accept cycle until DONE.
// Option  : define MEM_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of
//           silently clearing the low address bits.
module data_mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign,
    output logic        stallreq,
    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [31:0] sram_addr,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [31:0] addr_q;
    logic [3:0]  strb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    // Accept-time values derived from the incoming request
    logic [31:0] addr_d;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d;
    // Load data extracted from the bus using the latched request
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_d;

`ifdef MEM_ALIGN_CHECK_EN
    logic        mis_q;
    logic        mis_d;
`endif

    // Decode the incoming request into bus address, strobes and replicated store data
    always_comb begin
        addr_d  = req_addr;
        strb_d  = 4'b1111;
        wdata_d = req_wdata;
`ifdef MEM_ALIGN_CHECK_EN
        mis_d   = 1'b0;
`endif
        case (req_size)
            2'd0: begin
                strb_d  = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                strb_d  = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata[15:0]}};
`ifdef MEM_ALIGN_CHECK_EN
                mis_d   = req_addr[0];
`else
                addr_d[0] = 1'b0;
`endif
            end
            default: begin
                // size 3 is treated as a word access
                strb_d  = 4'b1111;
                wdata_d = req_wdata;
`ifdef MEM_ALIGN_CHECK_EN
                mis_d   = |req_addr[1:0];
`else
                addr_d[1:0] = 2'b00;
`endif
            end
        endcase
        // reads never enable byte lanes
        if (!req_we) begin
            strb_d = 4'b0000;
        end
    end

    // Pick the addressed byte/half out of the word-aligned read data and extend it
    always_comb begin
        byte_sel = sram_rdata[7:0];
        case (addr_q[1:0])
            2'd0:    byte_sel = sram_rdata[7:0];
            2'd1:    byte_sel = sram_rdata[15:8];
            2'd2:    byte_sel = sram_rdata[23:16];
            default: byte_sel = sram_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
        case (size_q)
            2'd0:    load_d = {{24{sign_q & byte_sel[7]}}, byte_sel};
            2'd1:    load_d = {{16{sign_q & half_sel[15]}}, half_sel};
            default: load_d = sram_rdata;
        endcase
        // stores complete with zero response data
        if (we_q) begin
            load_d = 32'h0;
        end
    end

    // Transaction FSM with the request latches and response data register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            addr_q  <= 32'h0;
            strb_q  <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        sign_q  <= req_sign;
                        addr_q  <= addr_d;
                        strb_q  <= strb_d;
                        wdata_q <= wdata_d;
`ifdef MEM_ALIGN_CHECK_EN
                        mis_q   <= mis_d;
                        if (mis_d) begin
                            // faulted access skips the bus entirely
                            rdata_q <= 32'h0;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ADDR;
                        end
`else
                        state_q <= S_ADDR;
`endif
                    end
                end
                S_ADDR: begin
                    // data_ok is deliberately ignored until the address phase is accepted
                    if (sram_addr_ok) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (sram_data_ok) begin
                        rdata_q <= load_d;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are state decodes and latched request fields
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_rdata = rdata_q;
    assign stallreq   = ((state_q == S_IDLE) && req_valid) ||
                        (state_q == S_ADDR) || (state_q == S_DATA);
    assign sram_req   = (state_q == S_ADDR);
    assign sram_wr    = we_q;
    assign sram_size  = size_q;
    assign sram_addr  = addr_q;
    assign sram_wstrb = strb_q;
    assign sram_wdata = wdata_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign   = mis_q & (state_q == S_DONE);
`else
    assign misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: table of load/store vectors driven through a scripted bus,
// response data and completion cycle checked by a scoreboard, plus a mid-transaction reset sequence.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, misalign, stallreq;
    logic [31:0] resp_rdata;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr, sram_wdata;
    logic [3:0]  sram_wstrb;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;

    data_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign(misalign), .stallreq(stallreq),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
        .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aw;
        int          dw;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t tbl[12];

    // Scoreboard: every completion pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got resp_valid=1 rdata=0x%08h expected no response (cycle %0d)",
                         resp_rdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_misalign", {31'b0, misalign}, {31'b0, mon_e.mis});
                chk("resp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic access(input vec_t v);
        int   c0;
        exp_t e;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_size  = v.size;
        req_sign  = v.sign;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        #1;
        chk("stall_accept", {31'b0, stallreq}, 32'd1);
        c0 = cyc;
        e.rdata = v.e_mis ? 32'h0 : v.e_rdata;
        e.mis   = v.e_mis;
        e.cyc   = v.e_mis ? c0 + 1 : c0 + 3 + v.aw + v.dw;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (v.e_mis) begin
            chk("mis_no_sram_req", {31'b0, sram_req}, 32'd0);
            chk("mis_stall_low", {31'b0, stallreq}, 32'd0);
        end else begin
            for (int i = 0; i <= v.aw; i++) begin
                chk("addr_sram_req", {31'b0, sram_req}, 32'd1);
                chk("addr_stall", {31'b0, stallreq}, 32'd1);
                chk("sram_wr", {31'b0, sram_wr}, {31'b0, v.we});
                chk("sram_size", {30'b0, sram_size}, {30'b0, v.size});
                chk("sram_addr", sram_addr, v.e_addr);
                chk("sram_wstrb", {28'b0, sram_wstrb}, {28'b0, v.e_strb});
                chk("sram_wdata", sram_wdata, v.e_wdata);
                sram_addr_ok = (i == v.aw);
                sram_data_ok = (i != v.aw);  // early data_ok must be ignored in ADDR
                @(negedge clk);
            end
            sram_addr_ok = 1'b0;
            sram_data_ok = 1'b0;
            for (int i = 0; i <= v.dw; i++) begin
                chk("data_sram_req_low", {31'b0, sram_req}, 32'd0);
                chk("data_stall", {31'b0, stallreq}, 32'd1);
                sram_data_ok = (i == v.dw);
                sram_rdata   = (i == v.dw) ? v.rdata : 32'h5A5A5A5A;
                @(negedge clk);
            end
            sram_data_ok = 1'b0;
            sram_rdata   = $urandom;
            chk("done_stall_low", {31'b0, stallreq}, 32'd0);
            chk("done_ready_low", {31'b0, req_ready}, 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_misalign"}, {31'b0, misalign}, 32'd0);
        chk({tag, "_stallreq"}, {31'b0, stallreq}, 32'd0);
        chk({tag, "_sram_req"}, {31'b0, sram_req}, 32'd0);
        chk({tag, "_sram_wr"}, {31'b0, sram_wr}, 32'd0);
        chk({tag, "_sram_size"}, {30'b0, sram_size}, 32'd0);
        chk({tag, "_sram_addr"}, sram_addr, 32'd0);
        chk({tag, "_sram_wstrb"}, {28'b0, sram_wstrb}, 32'd0);
        chk({tag, "_sram_wdata"}, sram_wdata, 32'd0);
    endtask

    initial begin
        // fields: we size sign addr wdata rdata aw dw | e_addr e_strb e_wdata e_rdata e_mis
        tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 32'h103, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 32'h103, 4'b0000, 32'h0, 32'h00000080, 1'b0};
        tbl[3]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 32'h55555555, 2, 0, 32'h102, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h001, 32'h000000A5, 32'hFFFFFFFF, 0, 1, 32'h001, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h002, 32'h0, 32'h80011234, 0, 0, 32'h002, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h000, 32'h0, 32'h8001F234, 1, 2, 32'h000, 4'b0000, 32'h0, 32'h0000F234, 1'b0};
        tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h000, 32'h0, 32'h0000F234, 0, 0, 32'h000, 4'b0000, 32'h0, 32'hFFFFF234, 1'b0};
        tbl[8]  = '{1'b1, 2'd3, 1'b0, 32'h200, 32'hCAFEF00D, 32'h0, 0, 0, 32'h200, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 32'h127F0000, 0, 0, 32'h102, 4'b0000, 32'h0, 32'h0000007F, 1'b0};
`ifdef MEM_ALIGN_CHECK_EN
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h11223344, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h103, 32'h0000BEEF, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
`else
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h11223344, 0, 0, 32'h100, 4'b0000, 32'h0, 32'h11223344, 1'b0};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h103, 32'h0000BEEF, 32'h0, 0, 0, 32'h102, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0};
`endif

        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b1;

        for (int k = 0; k < 12; k++) begin
            access(tbl[k]);
        end

        // Reset in the middle of a store's data phase, then a late data_ok
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_sign = 1'b0;
        req_addr = 32'h300; req_wdata = 32'h87654321;
        @(negedge clk);
        req_valid = 1'b0;
        sram_addr_ok = 1'b1;
        @(negedge clk);
        sram_addr_ok = 1'b0;
        chk("rst_pre_data_stall", {31'b0, stallreq}, 32'd1);
        chk("rst_pre_wstrb", {28'b0, sram_wstrb}, 32'hF);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sram_data_ok = 1'b1;
        sram_rdata   = 32'hFEEDFACE;
        @(negedge clk);
        sram_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_data_ok_no_resp", {31'b0, resp_valid}, 32'd0);
            chk("late_data_ok_idle", {31'b0, req_ready}, 32'd1);
            @(negedge clk);
        end

        // Controller recovers cleanly after the aborted transaction
        access(tbl[0]);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
